// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator stage: command encodings,
// default data width and small result helpers.
package acc_pkg;

  // Default data width of operand, accumulator and result.
  localparam int ACC_WIDTH = 4;

  // Command encodings presented on the cmd input.
  typedef enum logic [1:0] {
    CMD_CLR  = 2'b00,
    CMD_LOAD = 2'b01,
    CMD_ADD  = 2'b10,
    CMD_SUB  = 2'b11
  } acc_cmd_e;

  // Zero detect over a packed value, used for the Z flag.
  function automatic logic is_zero4(input logic [ACC_WIDTH-1:0] val);
    return (val == {ACC_WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational WIDTH-bit add/subtract built as a ripple chain of full-adder
// cells with a carry-in. Subtraction feeds the inverted operand with carry-in 1,
// so the carry out reads as "no borrow".
module acc_alu
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_s,
  output logic             o_c,
  output logic             o_v
);

  logic [WIDTH-1:0] w_opb;
  logic [WIDTH:0]   w_carry;

  // Select the second operand: b for ADD, ~b for SUB (carry-in supplies the +1).
  always_comb begin
    w_opb = i_b;
    if (i_sub) begin
      w_opb = ~i_b;
    end else begin
      w_opb = i_b;
    end
  end

  // Ripple chain of full-adder cells; carry-in equals the subtract select.
  always_comb begin
    o_s        = {WIDTH{1'b0}};
    w_carry    = {(WIDTH+1){1'b0}};
    w_carry[0] = i_sub;
    for (int i = 0; i < WIDTH; i++) begin
      o_s[i]       = i_a[i] ^ w_opb[i] ^ w_carry[i];
      w_carry[i+1] = (i_a[i] & w_opb[i]) | (w_carry[i] & (i_a[i] ^ w_opb[i]));
    end
  end

  // Carry out and signed overflow: operands agree in sign, result disagrees.
  always_comb begin
    o_c = w_carry[WIDTH];
    o_v = (i_a[WIDTH-1] == w_opb[WIDTH-1]) && (o_s[WIDTH-1] != i_a[WIDTH-1]);
  end

endmodule

// File: rtl/acc_stage.sv
// Registered accumulator stage with a single-entry valid/ready output.
// Each accepted command updates the accumulator and latches result, flags and
// a sticky overflow bit; the result is held until downstream consumes it.
module acc_stage
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       cmd,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             ovf_sticky
);

  logic [WIDTH-1:0] r_acc;
  logic             r_out_valid;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_v;
  logic             r_sticky;

  logic             w_accept;
  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_alu_c;
  logic             w_alu_v;

  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_out_valid_nxt;
  logic             w_c_nxt;
  logic             w_v_nxt;
  logic             w_sticky_nxt;

  acc_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a   (r_acc),
    .i_b   (b),
    .i_sub (w_sub),
    .o_s   (w_sum),
    .o_c   (w_alu_c),
    .o_v   (w_alu_v)
  );

  // Handshake: the single output entry frees up when empty or being consumed.
  always_comb begin
    in_ready = !r_out_valid || out_ready;
    w_accept = in_valid && in_ready;
    w_sub    = (cmd == CMD_SUB);
  end

  // Next accumulator, flags, sticky and valid for the coming edge.
  always_comb begin
    w_acc_nxt       = r_acc;
    w_c_nxt         = r_c;
    w_v_nxt         = r_v;
    w_sticky_nxt    = r_sticky;
    w_out_valid_nxt = r_out_valid;
    if (w_accept) begin
      w_out_valid_nxt = 1'b1;
      case (acc_cmd_e'(cmd))
        CMD_CLR: begin
          w_acc_nxt    = {WIDTH{1'b0}};
          w_c_nxt      = 1'b0;
          w_v_nxt      = 1'b0;
          w_sticky_nxt = 1'b0;
        end
        CMD_LOAD: begin
          w_acc_nxt = b;
          w_c_nxt   = 1'b0;
          w_v_nxt   = 1'b0;
        end
        CMD_ADD, CMD_SUB: begin
          w_acc_nxt    = w_sum;
          w_c_nxt      = w_alu_c;
          w_v_nxt      = w_alu_v;
          w_sticky_nxt = r_sticky | w_alu_v;
        end
        default: begin
          w_acc_nxt = r_acc;
        end
      endcase
    end else if (out_ready) begin
      w_out_valid_nxt = 1'b0;
    end else begin
      w_out_valid_nxt = r_out_valid;
    end
  end

  // State registers; reset discards any pending result immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_z         <= 1'b1;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_sticky    <= 1'b0;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      if (w_accept) begin
        r_acc    <= w_acc_nxt;
        r_z      <= is_zero4(w_acc_nxt);
        r_n      <= w_acc_nxt[WIDTH-1];
        r_c      <= w_c_nxt;
        r_v      <= w_v_nxt;
        r_sticky <= w_sticky_nxt;
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    out_valid  = r_out_valid;
    q          = r_acc;
    flag_z     = r_z;
    flag_n     = r_n;
    flag_c     = r_c;
    flag_v     = r_v;
    ovf_sticky = r_sticky;
  end

endmodule

// File: tb/tb_acc_stage.sv
// Scoreboard bench for acc_stage: a driver pushes expected results computed by
// an integer reference model; a monitor compares whatever the DUT presents.
module tb_acc_stage;
  import acc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] cmd;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] q;
  logic       flag_z, flag_n, flag_c, flag_v, ovf_sticky;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int         m_acc    = 0;
  logic       m_sticky = 1'b0;
  logic       m_ov     = 1'b0;
  logic [8:0] exp_q[$];   // {q, z, n, c, v, sticky}

  acc_stage #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .cmd(cmd), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .q(q),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: two's complement rules with plain integer arithmetic.
  task automatic apply_cmd(input logic [1:0] c, input logic [3:0] bb);
    int a, bv, sa, sb, r, res;
    logic cf, vf;
    logic [3:0] rq;
    a = m_acc; bv = int'(bb);
    sa = (a > 7) ? a - 16 : a;
    sb = (bv > 7) ? bv - 16 : bv;
    cf = 1'b0; vf = 1'b0; res = a;
    case (c)
      2'd0: begin res = 0; m_sticky = 1'b0; end
      2'd1: res = bv;
      2'd2: begin
        res = (a + bv) % 16; cf = (a + bv) > 15;
        r = sa + sb; vf = (r > 7) || (r < -8);
      end
      default: begin
        res = (a - bv + 16) % 16; cf = (a >= bv);
        r = sa - sb; vf = (r > 7) || (r < -8);
      end
    endcase
    m_sticky = m_sticky | vf;
    m_acc = res;
    rq = res[3:0];
    exp_q.push_back({rq, res == 0, res > 7, cf, vf, m_sticky});
  endtask

  // One cycle of stimulus: set inputs after the edge, predict at the negedge.
  task automatic drive(input logic v, input logic [1:0] c, input logic [3:0] bb,
                       input logic ordy, output logic accepted);
    logic exp_ready;
    in_valid = v; cmd = c; b = bb; out_ready = ordy;
    @(negedge clk);
    exp_ready = !m_ov || out_ready;
    check("in_ready", {8'd0, in_ready}, {8'd0, exp_ready});
    check("out_valid", {8'd0, out_valid}, {8'd0, m_ov});
    accepted = v && exp_ready;
    if (accepted) begin
      apply_cmd(c, bb);
      m_ov = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end else begin
      m_ov = m_ov;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [1:0] c, input logic [3:0] bb, input logic ordy);
    logic acc_d;
    drive(1'b1, c, bb, ordy, acc_d);
  endtask

  // Monitor: whatever result the DUT presents must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL result_unexpected: got q=%h with no expected entry at %0t", q, $time);
      end else begin
        check("result", {q, flag_z, flag_n, flag_c, flag_v, ovf_sticky}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic acc_d;
    logic [1:0] hc;
    logic [3:0] hb;
    logic hv;
    rst = 1'b1; in_valid = 1'b0; cmd = 2'd0; b = 4'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {q, flag_z, flag_n, flag_c, flag_v, ovf_sticky}, 9'b0000_1_0_0_0_0);
    check("reset_valid", {8'd0, out_valid}, 9'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases from the arithmetic rules.
    run(CMD_LOAD, 4'h4, 1'b1); run(CMD_ADD, 4'h3, 1'b1);
    run(CMD_LOAD, 4'h4, 1'b1); run(CMD_ADD, 4'h4, 1'b1); run(CMD_CLR, 4'h9, 1'b1);
    run(CMD_LOAD, 4'hC, 1'b1); run(CMD_ADD, 4'hC, 1'b1);
    run(CMD_LOAD, 4'hC, 1'b1); run(CMD_ADD, 4'hB, 1'b1);
    run(CMD_LOAD, 4'h3, 1'b1); run(CMD_SUB, 4'h5, 1'b1);
    run(CMD_LOAD, 4'h8, 1'b1); run(CMD_SUB, 4'h1, 1'b1);

    // Backpressure: hold three cycles, then accept on release.
    run(CMD_LOAD, 4'h5, 1'b0);
    repeat (3) run(CMD_ADD, 4'h2, 1'b0);
    run(CMD_ADD, 4'h2, 1'b1);
    drive(1'b0, CMD_CLR, 4'h0, 1'b1, acc_d);

    // Reset while a result is held.
    run(CMD_LOAD, 4'h4, 1'b1);
    run(CMD_ADD, 4'h4, 1'b0);
    drive(1'b0, CMD_CLR, 4'h0, 1'b0, acc_d);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_reset", {q, out_valid, flag_z, ovf_sticky, 2'b00}, {4'h0, 1'b0, 1'b1, 1'b0, 2'b00});
    exp_q.delete(); m_acc = 0; m_sticky = 1'b0; m_ov = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic; a refused command is held stable upstream.
    hv = 1'b0; hc = 2'd0; hb = 4'd0;
    for (int i = 0; i < 400; i++) begin
      if (!hv) begin
        hv = ($urandom_range(0, 9) < 7);
        hc = 2'($urandom_range(0, 3));
        hb = 4'($urandom_range(0, 15));
      end
      drive(hv, hc, hb, ($urandom_range(0, 9) < 7), acc_d);
      if (acc_d || !hv) hv = 1'b0;
    end

    // Drain and confirm nothing is left outstanding.
    repeat (2) drive(1'b0, CMD_CLR, 4'h0, 1'b1, acc_d);
    check("drain_empty", 9'(exp_q.size()), 9'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
